// File: rtl/eight_if.sv
// Beat/result bundle between the vector x vector wrapper and the dot-product engine.
// The wrapper owns the rows and the beat qualifier; the engine returns the sum and finish.
interface eight_if;
    logic [511:0] first_row_input;
    logic [511:0] second_row_input;
    logic         outsider_read_now;
    logic [63:0]  result;
    logic         finish;

    modport master (
        output first_row_input,
        output second_row_input,
        output outsider_read_now,
        input  result,
        input  finish
    );

    modport slave (
        input  first_row_input,
        input  second_row_input,
        input  outsider_read_now,
        output result,
        output finish
    );
endinterface

// File: rtl/eight.sv
// Eight-lane conj(A).B dot product over NOE elements; finish rises 3 clocks after the last beat.
// No backpressure: beats qualify on outsider_read_now, surplus beats and beats after finish are dropped.
module eight #(
    parameter int NOE = 16
) (
    input  logic  clk,
    input  logic  reset,
    eight_if.slave bus
);
    localparam int LANES = 8;
    localparam int BEATS = (NOE + LANES - 1) / LANES;
    localparam int CW    = $clog2(BEATS + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  beat_cnt;
    logic           accept;
    logic           is_last;
    logic           finish;

    logic           in_vld, in_last;
    logic [511:0]   a_dat, b_dat;

    logic [31:0]    lane_re [LANES];
    logic [31:0]    lane_im [LANES];

    logic           s1_vld, s1_last;
    logic [31:0]    s1_re [LANES];
    logic [31:0]    s1_im [LANES];

    logic [31:0]    l1_re [4];
    logic [31:0]    l1_im [4];
    logic [31:0]    l2_re [2];
    logic [31:0]    l2_im [2];
    logic [31:0]    sum_re, sum_im;

    logic           s2_vld, s2_last;
    logic [31:0]    s2_re, s2_im;
    logic [31:0]    acc_re, acc_im;

    assign finish  = (state_q == DONE);
    assign is_last = (beat_cnt == CW'(BEATS - 1));
    assign accept  = bus.outsider_read_now && !finish && (beat_cnt < CW'(BEATS));

    assign bus.finish = finish;
    assign bus.result = {acc_re, acc_im};

    // Beat capture stage: rows are only sampled on an accepted beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_cnt <= '0;
            in_vld   <= 1'b0;
            in_last  <= 1'b0;
            a_dat    <= '0;
            b_dat    <= '0;
        end else begin
            in_vld  <= accept;
            in_last <= accept && is_last;
            if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
                a_dat    <= bus.first_row_input;
                b_dat    <= bus.second_row_input;
            end
        end
    end

    // Low 32 bits of a 64-bit product equal the 32-bit product, so lanes compute at 32 bits.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [31:0] ar, ai, br, bi;
        assign ar = a_dat[64*k+32 +: 32];
        assign ai = a_dat[64*k    +: 32];
        assign br = b_dat[64*k+32 +: 32];
        assign bi = b_dat[64*k    +: 32];
        assign lane_re[k] = ar * br + ai * bi;
        assign lane_im[k] = ar * bi - ai * br;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                s1_re[k] <= '0;
                s1_im[k] <= '0;
            end
        end else begin
            s1_vld  <= in_vld;
            s1_last <= in_last;
            if (in_vld) begin
                for (int k = 0; k < LANES; k++) begin
                    s1_re[k] <= lane_re[k];
                    s1_im[k] <= lane_im[k];
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            l1_re[k] = s1_re[2*k] + s1_re[2*k+1];
            l1_im[k] = s1_im[2*k] + s1_im[2*k+1];
        end
        for (int k = 0; k < 2; k++) begin
            l2_re[k] = l1_re[2*k] + l1_re[2*k+1];
            l2_im[k] = l1_im[2*k] + l1_im[2*k+1];
        end
        sum_re = l2_re[0] + l2_re[1];
        sum_im = l2_im[0] + l2_im[1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_vld  <= 1'b0;
            s2_last <= 1'b0;
            s2_re   <= '0;
            s2_im   <= '0;
            acc_re  <= '0;
            acc_im  <= '0;
        end else begin
            s2_vld  <= s1_vld;
            s2_last <= s1_last;
            if (s1_vld) begin
                s2_re <= sum_re;
                s2_im <= sum_im;
            end
            if (s2_vld) begin
                acc_re <= acc_re + s2_re;
                acc_im <= acc_im + s2_im;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // DONE is entered on the same edge that folds the last beat into the accumulator.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = is_last ? DRAIN : ACCUM;
            ACCUM:   if (accept && is_last) state_d = DRAIN;
            DRAIN:   if (s2_vld && s2_last) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_eight.sv
// Randomized bench for eight: a lane-by-lane arithmetic model predicts the sum and the finish latency.
module tb_eight;
    localparam int BEATS = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [511:0] a_in, b_in;
    logic         rn;

    int nvec = 0;
    int nerr = 0;
    int edge_n = 0;
    int rise16, rise12, acc_edge, mcnt;
    logic [31:0] mre, mim;

    always #5 clk = ~clk;

    eight_if i16 ();
    eight_if i12 ();

    assign i16.first_row_input   = a_in;
    assign i16.second_row_input  = b_in;
    assign i16.outsider_read_now = rn;
    assign i12.first_row_input   = a_in;
    assign i12.second_row_input  = b_in;
    assign i12.outsider_read_now = rn;

    eight #(.NOE(16)) u16 (.clk(clk), .reset(reset), .bus(i16));
    eight #(.NOE(12)) u12 (.clk(clk), .reset(reset), .bus(i12));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        if (i16.finish && rise16 < 0) rise16 = edge_n;
        if (i12.finish && rise12 < 0) rise12 = edge_n;
    endtask

    function automatic logic [511:0] mk_beat(input logic [31:0] re, input logic [31:0] im, input int nl);
        logic [511:0] r;
        r = '0;
        for (int k = 0; k < nl; k++) r[64*k +: 64] = {re, im};
        return r;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    // Reference: sum over lanes of conj(a)*b, products taken at 64 bits then truncated.
    task automatic model_add(input logic [511:0] a, input logic [511:0] b);
        logic [31:0] ar, ai, br, bi;
        longint p1, p2;
        for (int k = 0; k < 8; k++) begin
            ar = a[64*k+32 +: 32]; ai = a[64*k +: 32];
            br = b[64*k+32 +: 32]; bi = b[64*k +: 32];
            p1 = longint'($signed(ar)) * longint'($signed(br));
            p2 = longint'($signed(ai)) * longint'($signed(bi));
            mre = mre + p1[31:0] + p2[31:0];
            p1 = longint'($signed(ar)) * longint'($signed(bi));
            p2 = longint'($signed(ai)) * longint'($signed(br));
            mim = mim + p1[31:0] - p2[31:0];
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        rn = 1'b0;
        tick();
        tick();
        chk("rst_res16", i16.result, 64'd0);
        chk("rst_fin16", {63'd0, i16.finish}, 64'd0);
        chk("rst_res12", i12.result, 64'd0);
        chk("rst_fin12", {63'd0, i12.finish}, 64'd0);
        reset = 1'b1;
    endtask

    task automatic run_op(input string tag, input int kind, input int gap, input int nbeats,
                          input int post, input logic [63:0] want, input bit use_want);
        mre = '0; mim = '0; mcnt = 0;
        rise16 = -1; rise12 = -1; acc_edge = -1;
        for (int i = 0; i < nbeats; i++) begin
            if (i == 1) repeat (gap) begin
                rn = 1'b0;
                tick();
            end
            if (i >= BEATS) begin
                a_in = rnd512(); b_in = rnd512();
            end else begin
                case (kind)
                    0: begin a_in = mk_beat(1, 0, 8); b_in = mk_beat(1, 0, 8); end
                    1: begin a_in = mk_beat(0, 1, 8); b_in = mk_beat(0, 1, 8); end
                    2: begin a_in = mk_beat(2, 3, 8); b_in = mk_beat(4, 5, 8); end
                    3: begin
                        a_in = mk_beat(1, 0, (i == 0) ? 8 : 4);
                        b_in = mk_beat(1, 0, (i == 0) ? 8 : 4);
                    end
                    default: begin a_in = rnd512(); b_in = rnd512(); end
                endcase
            end
            rn = 1'b1;
            if (mcnt < BEATS) begin
                model_add(a_in, b_in);
                mcnt++;
                if (mcnt == BEATS) acc_edge = edge_n + 1;
            end
            tick();
        end
        rn = 1'b0;
        for (int w = 0; w < 12 && (rise16 < 0 || rise12 < 0); w++) tick();
        repeat (post) begin
            a_in = rnd512(); b_in = rnd512(); rn = 1'b1;
            tick();
        end
        rn = 1'b0;
        tick();
        chk({tag, "_lat16"}, 64'(rise16 - acc_edge), 64'd3);
        chk({tag, "_lat12"}, 64'(rise12 - acc_edge), 64'd3);
        chk({tag, "_res16"}, i16.result, {mre, mim});
        chk({tag, "_res12"}, i12.result, {mre, mim});
        chk({tag, "_fin16"}, {63'd0, i16.finish}, 64'd1);
        chk({tag, "_fin12"}, {63'd0, i12.finish}, 64'd1);
        if (use_want) begin
            chk({tag, "_abs16"}, i16.result, want);
            chk({tag, "_abs12"}, i12.result, want);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; rn = 1'b0; a_in = '0; b_in = '0;
        #1;
        chk("t0_res16", i16.result, 64'd0);
        chk("t0_fin16", {63'd0, i16.finish}, 64'd0);
        @(negedge clk);

        do_reset(); run_op("ones",  0, 0, 4, 0, 64'h00000010_00000000, 1'b1);
        do_reset(); run_op("conj",  1, 0, 4, 0, 64'h00000010_00000000, 1'b1);
        do_reset(); run_op("mix",   2, 0, 4, 0, 64'h00000170_FFFFFFE0, 1'b1);
        do_reset(); run_op("gap",   0, 3, 4, 0, 64'h00000010_00000000, 1'b1);
        do_reset(); run_op("noe12", 3, 0, 4, 0, 64'h0000000C_00000000, 1'b1);

        // Abort one cycle after the first beat, then rerun from clean state.
        do_reset();
        a_in = mk_beat(1, 0, 8); b_in = mk_beat(1, 0, 8); rn = 1'b1;
        tick();
        rn = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("abort_res16", i16.result, 64'd0);
        chk("abort_fin16", {63'd0, i16.finish}, 64'd0);
        repeat (4) tick();
        chk("abort_hold16", i16.result, 64'd0);
        chk("abort_hold12", i12.result, 64'd0);
        reset = 1'b1;
        run_op("rerun", 0, 0, 4, 0, 64'h00000010_00000000, 1'b1);

        for (int it = 0; it < 8; it++) begin
            do_reset();
            run_op("rnd", 4, int'($urandom_range(0, 3)), int'($urandom_range(2, 4)),
                   int'($urandom_range(0, 3)), 64'd0, 1'b0);
            // Asynchronous clear from DONE, checked before the next clock edge.
            @(posedge clk);
            #2 reset = 1'b0;
            #1;
            chk("arst_res16", i16.result, 64'd0);
            chk("arst_fin16", {63'd0, i16.finish}, 64'd0);
            chk("arst_res12", i12.result, 64'd0);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
